// File: rtl/sipo_pkg.sv
// sipo_pkg: shared FSM state type and default word width for the SIPO deserializer
package sipo_pkg;
    localparam int SIPO_WIDTH = 4;
    typedef enum logic {S_DATA = 1'b0, S_PARITY = 1'b1} state_e;
endpackage

// File: rtl/sipo_out_buf.sv
// sipo_out_buf: single-entry output holding register with valid/ready handshake and sticky overrun
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             load_perr,
    input  logic [WIDTH-1:0] word,
    input  logic             pout_ready,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    output logic             overrun,
    output logic             parity_err
);
    logic [WIDTH-1:0] pout_q, pout_d;
    logic valid_q, valid_d, overrun_q, overrun_d, perr_q, perr_d, take;
    always_comb begin
        take      = load && (!valid_q || pout_ready);
        pout_d    = take ? word : pout_q;
        valid_d   = take || (valid_q && !pout_ready);
        overrun_d = overrun_q || (load && !take);
        perr_d    = take && load_perr;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            pout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            pout_q    <= pout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end
    assign pout       = pout_q;
    assign pout_valid = valid_q;
    assign overrun    = overrun_q;
    assign parity_err = perr_q;
endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: MSB-first serial-to-parallel word assembler with sync and output handshake
// Define SIPO_PARITY_EN to append an even-parity bit to every frame and flag mismatches.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             overrun,
    output logic             parity_err
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    logic [WIDTH-1:0] shreg_q, shreg_d, word;
    logic [CW-1:0] cnt_q, cnt_d;
    logic accept, last_data, done, perr;
    assign accept    = sin_valid && !sync;
    assign last_data = cnt_q == CW'(WIDTH - 1);
`ifdef SIPO_PARITY_EN
    state_e state_q, state_d;
    logic in_data;
    always_comb begin
        in_data = state_q == S_DATA;
        shreg_d = sync ? '0 : (accept && in_data) ? WIDTH'({shreg_q, sin}) : shreg_q;
        cnt_d   = sync ? '0 : (accept && in_data) ? (last_data ? '0 : cnt_q + CW'(1)) : cnt_q;
        state_d = sync ? S_DATA
                : !accept ? state_q
                : in_data ? (last_data ? S_PARITY : S_DATA)
                : S_DATA;
    end
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_DATA;
        else      state_q <= state_d;
    end
    // The parity bit arrives after the data, so the word is already complete in the shifter.
    assign done = accept && !in_data;
    assign word = shreg_q;
    assign perr = ^{shreg_q, sin};
`else
    always_comb begin
        shreg_d = sync ? '0 : accept ? WIDTH'({shreg_q, sin}) : shreg_q;
        cnt_d   = sync ? '0 : accept ? (last_data ? '0 : cnt_q + CW'(1)) : cnt_q;
    end
    assign done = accept && last_data;
    assign word = WIDTH'({shreg_q, sin});
    assign perr = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end
    sipo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (done),
        .load_perr (perr),
        .word      (word),
        .pout_ready(pout_ready),
        .pout      (pout),
        .pout_valid(pout_valid),
        .overrun   (overrun),
        .parity_err(parity_err)
    );
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed and randomized checks of sipo_deserializer against a frame-level model
module tb_sipo_deserializer;
    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sin = 1'b0, sin_valid = 1'b0, sync = 1'b0, pout_ready = 1'b0;
    logic [W-1:0] pout;
    logic pout_valid, overrun, parity_err;
    int n_checks = 0, n_fail = 0;

    bit frame[$];
    logic [W-1:0] m_pout = '0;
    bit m_valid = 0, m_ovr = 0, m_perr = 0;

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sync(sync),
        .pout(pout), .pout_valid(pout_valid), .pout_ready(pout_ready),
        .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference: collect bits, form the word arithmetically when the frame is full.
    task automatic model(input bit b, input bit v, input bit s, input bit r, input bit rn);
        bit done, perr;
        int ones;
        logic [W-1:0] w;
        done = 0; perr = 0; ones = 0; w = '0;
        if (!rn) begin
            frame.delete();
            m_pout = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
            return;
        end
        if (s) frame.delete();
        else if (v) begin
            frame.push_back(b);
            if (frame.size() == FRAME) begin
                done = 1;
                for (int i = 0; i < W; i++) w = W'(w * 2 + frame[i]);
                for (int i = 0; i < FRAME; i++) ones += frame[i];
`ifdef SIPO_PARITY_EN
                perr = ones % 2 == 1;
`endif
                frame.delete();
            end
        end
        m_perr = 0;
        if (done && m_valid && !r) m_ovr = 1;
        else if (done) begin
            m_pout = w; m_valid = 1; m_perr = perr;
        end else if (m_valid && r) m_valid = 0;
    endtask

    task automatic step(input bit b, input bit v, input bit s, input bit r, input bit rn = 1);
        sin = b; sin_valid = v; sync = s; pout_ready = r; rst = rn;
        model(b, v, s, r, rn);
        @(posedge clk);
        #1;
        check("pout", 32'(pout), 32'(m_pout));
        check("pout_valid", 32'(pout_valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("parity_err", 32'(parity_err), 32'(m_perr));
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit r, input bit r_last);
        for (int i = W - 1; i >= 0; i--)
            step(w[i], 1, 0, (FRAME == W && i == 0) ? r_last : r);
`ifdef SIPO_PARITY_EN
        step(^w, 1, 0, r_last);
`endif
    endtask

    initial begin
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rst_pout", 32'(pout), 32'h0);
        check("rst_valid", 32'(pout_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        send_word(4'b1011, 0, 0);
        check("first_word", 32'(pout), 32'hB);
        check("first_valid", 32'(pout_valid), 32'h1);

        send_word(4'b0110, 0, 0);
        check("ovr_hold_pout", 32'(pout), 32'hB);
        check("ovr_set", 32'(overrun), 32'h1);
        step(0, 0, 0, 1);
        check("drain_valid", 32'(pout_valid), 32'h0);
        step(0, 0, 0, 0);
        check("ovr_sticky", 32'(overrun), 32'h1);

        step(0, 0, 0, 0, 0);
        send_word(4'b1011, 0, 0);
        send_word(4'b0101, 0, 1);
        check("swap_pout", 32'(pout), 32'h5);
        check("swap_valid", 32'(pout_valid), 32'h1);
        check("swap_ovr", 32'(overrun), 32'h0);

        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        step(1, 1, 1, 1);
        send_word(4'b0011, 1, 1);
        check("sync_pout", 32'(pout), 32'h3);

        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
        send_word(4'b1001, 1, 1);
        check("idle_pout", 32'(pout), 32'h9);

        step(1, 1, 0, 1);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1, 0);
        send_word(4'b1110, 0, 0);
        check("rst_mid_pout", 32'(pout), 32'hE);
        check("rst_mid_ovr", 32'(overrun), 32'h0);

`ifdef SIPO_PARITY_EN
        step(0, 0, 0, 1);
        step(1, 1, 0, 1); step(0, 1, 0, 1); step(1, 1, 0, 1); step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        check("par_ok_pout", 32'(pout), 32'hA);
        check("par_ok_err", 32'(parity_err), 32'h0);
        step(1, 1, 0, 1); step(0, 1, 0, 1); step(1, 1, 0, 1); step(0, 1, 0, 1);
        step(1, 1, 0, 1);
        check("par_bad_pout", 32'(pout), 32'hA);
        check("par_bad_err", 32'(parity_err), 32'h1);
        step(0, 0, 0, 0);
        check("par_pulse_end", 32'(parity_err), 32'h0);
`endif

        for (int i = 0; i < 3000; i++)
            step(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                 1'($urandom), $urandom_range(0, 199) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
